// File: rtl/branch_resolve_unit_if.sv
// Branch resolution handshake between control unit/ALU (master) and branch_resolve_unit (slave).
interface branch_resolve_unit_if #(
  parameter int PC_W  = 32,
  parameter int IMM_W = 16,
  parameter int CNT_W = 16
);
  logic             br_req;
  logic [2:0]       br_type;
  logic [PC_W-1:0]  branch_pc;
  logic [IMM_W-1:0] br_imm;
  logic             flag_valid;
  logic             zero_flag;
  logic             carry_flag;
  logic             br_ack;
  logic             busy;
  logic             pc_write;
  logic [PC_W-1:0]  pc_next;
  logic             br_taken;
  logic             br_timeout;
  logic [CNT_W-1:0] taken_cnt;
  logic [CNT_W-1:0] resolv_cnt;

  modport master (
    output br_req, br_type, branch_pc, br_imm, flag_valid, zero_flag, carry_flag,
    input  br_ack, busy, pc_write, pc_next, br_taken, br_timeout, taken_cnt, resolv_cnt
  );

  modport slave (
    input  br_req, br_type, branch_pc, br_imm, flag_valid, zero_flag, carry_flag,
    output br_ack, busy, pc_write, pc_next, br_taken, br_timeout, taken_cnt, resolv_cnt
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Resolves a conditional branch from ALU SUB flags; flags in cycle N give pc_write in N+1, req-to-write >= 2 cycles.
// No queuing: br_req is refused (br_ack=0) while busy; missing flags force not-taken after TIMEOUT wait cycles.
module branch_resolve_unit #(
  parameter int PC_W    = 32,
  parameter int IMM_W   = 16,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input logic                    clk,
  input logic                    reset,
  branch_resolve_unit_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, WAIT_FLAGS, RESOLVE} state_t;

  state_t           r_state;
  logic [2:0]       r_type;
  logic [PC_W-1:0]  r_pc;
  logic [IMM_W-1:0] r_imm;
  logic             r_zf;
  logic             r_cf;
  logic [7:0]       r_tcnt;
  logic             r_busy;
  logic             r_pc_write;
  logic [PC_W-1:0]  r_pc_next;
  logic             r_taken;
  logic             r_timeout;
  logic [CNT_W-1:0] r_taken_cnt;
  logic [CNT_W-1:0] r_resolv_cnt;

  logic             w_zf;
  logic             w_cf;
  logic             w_cond;
  logic             w_expire;
  logic             w_resolve;
  logic             w_taken;
  logic [PC_W-1:0]  w_target;
  logic [PC_W-1:0]  w_fall;

  // Flags are used the cycle they arrive so pc_write can be registered one cycle later.
  assign w_zf = bus.flag_valid ? bus.zero_flag  : r_zf;
  assign w_cf = bus.flag_valid ? bus.carry_flag : r_cf;

  always_comb begin
    w_cond = 1'b0;
    case (r_type)
      3'd1:    w_cond = w_zf;
      3'd2:    w_cond = !w_zf;
      3'd3:    w_cond = !w_zf && w_cf;
      3'd4:    w_cond = !w_zf && !w_cf;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_expire  = (r_tcnt == 8'(TIMEOUT - 1));
  assign w_resolve = (r_state == WAIT_FLAGS) && (bus.flag_valid || w_expire);
  assign w_taken   = bus.flag_valid && w_cond;
  assign w_target  = r_pc + {{(PC_W-IMM_W){r_imm[IMM_W-1]}}, r_imm};
  assign w_fall    = r_pc + PC_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_type       <= '0;
      r_pc         <= '0;
      r_imm        <= '0;
      r_zf         <= 1'b0;
      r_cf         <= 1'b0;
      r_tcnt       <= '0;
      r_busy       <= 1'b0;
      r_pc_write   <= 1'b0;
      r_pc_next    <= '0;
      r_taken      <= 1'b0;
      r_timeout    <= 1'b0;
      r_taken_cnt  <= '0;
      r_resolv_cnt <= '0;
    end else begin
      r_pc_write <= 1'b0;
      r_timeout  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.br_req) begin
            r_type  <= bus.br_type;
            r_pc    <= bus.branch_pc;
            r_imm   <= bus.br_imm;
            r_tcnt  <= '0;
            r_busy  <= 1'b1;
            r_state <= WAIT_FLAGS;
          end
        end
        WAIT_FLAGS: begin
          if (bus.flag_valid) begin
            r_zf <= bus.zero_flag;
            r_cf <= bus.carry_flag;
          end
          if (w_resolve) begin
            r_state    <= RESOLVE;
            r_pc_write <= 1'b1;
            r_taken    <= w_taken;
            r_timeout  <= !bus.flag_valid;
            r_pc_next  <= w_taken ? w_target : w_fall;
            if (r_resolv_cnt != '1)
              r_resolv_cnt <= r_resolv_cnt + CNT_W'(1);
            if (w_taken && (r_taken_cnt != '1))
              r_taken_cnt <= r_taken_cnt + CNT_W'(1);
          end else begin
            r_tcnt <= r_tcnt + 8'd1;
          end
        end
        RESOLVE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.br_ack     = bus.br_req && (r_state == IDLE);
  assign bus.busy       = r_busy;
  assign bus.pc_write   = r_pc_write;
  assign bus.pc_next    = r_pc_next;
  assign bus.br_taken   = r_taken;
  assign bus.br_timeout = r_timeout;
  assign bus.taken_cnt  = r_taken_cnt;
  assign bus.resolv_cnt = r_resolv_cnt;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: expected resolutions queued at request time, popped on pc_write.
module tb_branch_resolve_unit;
  localparam int PC_W    = 32;
  localparam int IMM_W   = 16;
  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.PC_W(PC_W), .IMM_W(IMM_W), .CNT_W(CNT_W)) bus ();

  branch_resolve_unit #(.PC_W(PC_W), .IMM_W(IMM_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic        tmo;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   exp_tcnt = 0;
  int   exp_rcnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  function automatic logic model_taken(input logic [2:0] t, input logic z, input logic c);
    case (t)
      3'd1:    return z;
      3'd2:    return !z;
      3'd3:    return !z && c;
      3'd4:    return !z && !c;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_write;
    int   n;
    exp_t e;
    n = 0;
    while (bus.pc_write !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    check("write_latency", 32'(n), 32'd0);
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    if (exp_rcnt < CNT_MAX) exp_rcnt++;
    if (e.taken && exp_tcnt < CNT_MAX) exp_tcnt++;
    check("pc_next", bus.pc_next, e.pc);
    check("br_taken", 32'(bus.br_taken), 32'(e.taken));
    check("br_timeout", 32'(bus.br_timeout), 32'(e.tmo));
    check("busy_resolve", 32'(bus.busy), 32'd1);
    check("taken_cnt", 32'(bus.taken_cnt), 32'(exp_tcnt));
    check("resolv_cnt", 32'(bus.resolv_cnt), 32'(exp_rcnt));
    tick;
    check("write_oneshot", 32'(bus.pc_write), 32'd0);
    check("timeout_oneshot", 32'(bus.br_timeout), 32'd0);
    check("busy_after", 32'(bus.busy), 32'd0);
    check("pc_next_held", bus.pc_next, e.pc);
  endtask

  // idle = WAIT cycles without flags before the flag cycle (or before expiry when give_flag=0)
  task automatic run_branch(input logic [2:0] t, input logic [31:0] pc, input logic [15:0] imm,
                            input int idle, input bit give_flag, input logic z, input logic c,
                            input bit intrude, input bit accept_flag);
    exp_t e;
    logic tk;
    tk      = give_flag ? model_taken(t, z, c) : 1'b0;
    e.taken = tk;
    e.tmo   = !give_flag;
    e.pc    = tk ? pc + {{16{imm[15]}}, imm} : pc + 32'd1;
    exp_q.push_back(e);
    bus.br_req    = 1'b1;
    bus.br_type   = t;
    bus.branch_pc = pc;
    bus.br_imm    = imm;
    if (accept_flag) begin
      bus.flag_valid = 1'b1;
      bus.zero_flag  = 1'b1;
    end
    #1;
    check("br_ack", 32'(bus.br_ack), 32'd1);
    tick;
    bus.br_req     = 1'b0;
    bus.br_type    = 3'd0;
    bus.branch_pc  = '0;
    bus.br_imm     = '0;
    bus.flag_valid = 1'b0;
    bus.zero_flag  = 1'b0;
    check("busy_wait", 32'(bus.busy), 32'd1);
    for (int i = 0; i < idle; i++) begin
      if (intrude && i == 0) begin
        bus.br_req    = 1'b1;
        bus.br_type   = 3'd1;
        bus.branch_pc = 32'h500;
        #1;
        check("ack_busy", 32'(bus.br_ack), 32'd0);
      end
      check("no_early_write", 32'(bus.pc_write), 32'd0);
      tick;
      bus.br_req    = 1'b0;
      bus.br_type   = 3'd0;
      bus.branch_pc = '0;
    end
    if (give_flag) begin
      bus.flag_valid = 1'b1;
      bus.zero_flag  = z;
      bus.carry_flag = c;
      tick;
      bus.flag_valid = 1'b0;
      bus.zero_flag  = 1'b0;
      bus.carry_flag = 1'b0;
    end
    wait_write;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.br_req     = 1'b0;
    bus.br_type    = 3'd0;
    bus.branch_pc  = '0;
    bus.br_imm     = '0;
    bus.flag_valid = 1'b0;
    bus.zero_flag  = 1'b0;
    bus.carry_flag = 1'b0;
    tick;
    tick;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_pc_write", 32'(bus.pc_write), 32'd0);
    check("rst_pc_next", bus.pc_next, 32'd0);
    check("rst_taken", 32'(bus.br_taken), 32'd0);
    check("rst_timeout", 32'(bus.br_timeout), 32'd0);
    check("rst_cnts", 32'({bus.taken_cnt, bus.resolv_cnt}), 32'd0);
    reset = 1'b0;
    tick;

    // flags in IDLE must not start anything
    bus.flag_valid = 1'b1;
    bus.zero_flag  = 1'b1;
    tick;
    bus.flag_valid = 1'b0;
    bus.zero_flag  = 1'b0;
    check("idle_flag_busy", 32'(bus.busy), 32'd0);
    check("idle_flag_write", 32'(bus.pc_write), 32'd0);

    run_branch(3'd1, 32'h100, 16'h0010, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);  // BEQ taken
    run_branch(3'd4, 32'h100, 16'hFFFC, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);  // BLT negative offset

    // reset during WAIT_FLAGS abandons the branch
    bus.br_req    = 1'b1;
    bus.br_type   = 3'd1;
    bus.branch_pc = 32'h700;
    bus.br_imm    = 16'h0004;
    tick;
    bus.br_req = 1'b0;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    bus.flag_valid = 1'b1;
    bus.zero_flag  = 1'b1;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_write", 32'(bus.pc_write), 32'd0);
    check("mid_rst_pc_next", bus.pc_next, 32'd0);
    check("mid_rst_cnts", 32'({bus.taken_cnt, bus.resolv_cnt}), 32'd0);
    tick;
    bus.flag_valid = 1'b0;
    bus.zero_flag  = 1'b0;
    check("mid_rst_no_write", 32'(bus.pc_write), 32'd0);
    exp_tcnt = 0;
    exp_rcnt = 0;

    run_branch(3'd2, 32'h200, 16'h0040, 2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);          // BNE not taken, req while busy
    run_branch(3'd3, 32'h1000, 16'h7FFF, 3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);         // BGT taken
    run_branch(3'd1, 32'h300, 16'h0008, TIMEOUT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);    // timeout, accept-cycle flag ignored
    run_branch(3'd1, 32'h400, 16'h0020, TIMEOUT-1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);  // flag on expiry cycle wins
    run_branch(3'd0, 32'hFFFF_FFFF, 16'h0004, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);    // NONE, wrap to 0
    run_branch(3'd5, 32'h10, 16'h0004, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);           // reserved type
    run_branch(3'd1, 32'h20, 16'h0004, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);           // BEQ not taken
    run_branch(3'd4, 32'h30, 16'h0004, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);           // resolv_cnt saturates
    run_branch(3'd1, 32'hFFFF_FFF0, 16'h0020, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);    // taken target wraps

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
